dummy_accelerator_dispatch: RTL

//  Generalised front-end for N dummy execution units: routes each request to the unit selected by ctl_i
//  and returns results strictly in issue order. Replaces the fixed two-unit ctl shift pipeline with an

---
 rtl/dummy_accelerator_pkg.sv | 22 ++
 rtl/dummy_accelerator_dispatch_if.sv | 33 +++
 rtl/dummy_accelerator_order_fifo.sv | 61 ++++++
 rtl/dummy_accelerator_dispatch.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dummy_accelerator_pkg.sv
// -----------------------------------------------------------------------------
// dummy_accelerator_pkg
// Shared types and helpers for the dummy accelerator dispatch front-end.
//   DISPATCH_DEPTH_DEF : default number of in-flight operations
//   dispatch_err_t     : error code latched by the dispatcher
//   unit_idx()         : bit width of a unit index for a given unit count
// -----------------------------------------------------------------------------
package dummy_accelerator_pkg;

    localparam int unsigned DISPATCH_DEPTH_DEF = 8;

    typedef enum logic [0:0] {
        DISP_ERR_NONE        = 1'b0,
        DISP_ERR_ILLEGAL_CTL = 1'b1
    } dispatch_err_t;

    // Width of a unit index; a single unit still gets a 1-bit index.
    function automatic int unsigned unit_idx(input int unsigned n_units);
        return (n_units > 1) ? $clog2(n_units) : 1;
    endfunction

endpackage

// File: rtl/dummy_accelerator_dispatch_if.sv
// -----------------------------------------------------------------------------
// dummy_accelerator_dispatch_if
// CPU-side request/response bundle of the dispatcher. Signal suffixes are
// relative to the dispatcher (slave modport).
//   valid_i/ready_o/ctl_i      : request handshake and target unit index
//   valid_o/ready_i            : in-order result handshake
//   result_o/tag_o             : result and tag of the head operation
//   illegal_o                  : one-cycle pulse after an illegal ctl_i is accepted
// -----------------------------------------------------------------------------
interface dummy_accelerator_dispatch_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CTL_W      = 2,
    parameter type         TagType_t  = logic
);
    logic             valid_i;
    logic             ready_o;
    logic [CTL_W-1:0] ctl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    TagType_t         tag_o;
    logic             illegal_o;

    modport master (
        output valid_i, ctl_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o, illegal_o
    );

    modport slave (
        input  valid_i, ctl_i, ready_i,
        output ready_o, valid_o, result_o, tag_o, illegal_o
    );
endinterface

// File: rtl/dummy_accelerator_order_fifo.sv
// -----------------------------------------------------------------------------
// dummy_accelerator_order_fifo
// Records the unit index of each issued op so results can be returned in order.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : clear pointers next cycle; overrides push/pop
//   push_i/data_i : enqueue (ignored when full)
//   pop_i         : dequeue (ignored when empty)
//   full_o/empty_o: occupancy flags, from registered pointers only
//   head_o        : oldest entry
// -----------------------------------------------------------------------------
module dummy_accelerator_order_fifo #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // Pointer update; flush has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/dummy_accelerator_dispatch.sv
// -----------------------------------------------------------------------------
// dummy_accelerator_dispatch
// Routes CPU requests to N execution units by ctl_i and returns results in
// issue order using an order FIFO, independent of per-unit latency.
// Optional macro: DUMMY_ACC_DISPATCH_PERF_EN enables saturating perf counters;
// without it issue_cnt_o/stall_cnt_o are tied to zero.
// Ports:
//   clk_i, rst_ni   : clock, async active-low reset
//   flush_i         : clear ordering state and illegal_o next cycle
//   bus (slave)     : CPU request/response handshake, result, tag, illegal_o
//   unit_valid_o/unit_ready_i             : per-unit request handshake
//   unit_valid_i/unit_ready_o             : per-unit result handshake
//   unit_result_i/unit_tag_i              : per-unit result payload
//   issue_cnt_o/stall_cnt_o               : perf counters
// -----------------------------------------------------------------------------
module dummy_accelerator_dispatch
    import dummy_accelerator_pkg::*;
#(
    parameter int unsigned N_UNITS   = 2,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CTL_W     = 2,
    parameter int unsigned DEPTH     = DISPATCH_DEPTH_DEF,
    parameter type         TagType_t = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    dummy_accelerator_dispatch_if.slave bus,
    output logic [N_UNITS-1:0]         unit_valid_o,
    input  logic [N_UNITS-1:0]         unit_ready_i,
    input  logic [N_UNITS-1:0]         unit_valid_i,
    output logic [N_UNITS-1:0]         unit_ready_o,
    input  logic [WIDTH-1:0]           unit_result_i [N_UNITS],
    input  TagType_t                   unit_tag_i    [N_UNITS],
    output logic [31:0]                issue_cnt_o   [N_UNITS],
    output logic [31:0]                stall_cnt_o
);
    localparam int unsigned UIDX_W = unit_idx(N_UNITS);

    logic              w_full;
    logic              w_empty;
    logic              w_legal;
    logic              w_ready;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;
    logic              w_valid_o;
    logic [UIDX_W-1:0] w_sel;
    logic [UIDX_W-1:0] w_head;
    logic [WIDTH-1:0]  w_result;
    TagType_t          w_tag;
    dispatch_err_t     r_err;

    // Issue side: decode target, gate on FIFO space (registered, so no ready_i path).
    assign w_legal = (32'(bus.ctl_i) < N_UNITS);
    assign w_sel   = UIDX_W'(bus.ctl_i);
    assign w_ready = !w_full && (!w_legal || unit_ready_i[w_sel]);
    assign w_hs    = bus.valid_i && w_ready;
    assign w_push  = w_hs && w_legal;

    for (genvar k = 0; k < N_UNITS; k++) begin : g_unit
        assign unit_valid_o[k] = bus.valid_i && !w_full && w_legal && (w_sel == UIDX_W'(k));
        assign unit_ready_o[k] = !w_empty && (w_head == UIDX_W'(k)) && bus.ready_i;
    end

    // Return side: only the unit at the FIFO head is visible to the CPU.
    always_comb begin
        w_valid_o = 1'b0;
        w_result  = '0;
        w_tag     = '0;
        if (!w_empty) begin
            w_valid_o = unit_valid_i[w_head];
            w_result  = unit_result_i[w_head];
            w_tag     = unit_tag_i[w_head];
        end
    end

    assign w_pop = w_valid_o && bus.ready_i;

    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = w_valid_o;
    assign bus.result_o = w_result;
    assign bus.tag_o    = w_tag;

    dummy_accelerator_order_fifo #(
        .DATA_W (UIDX_W),
        .DEPTH  (DEPTH)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_push),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    // Illegal-ctl pulse: accepted but not routed anywhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= DISP_ERR_NONE;
        end else if (flush_i) begin
            r_err <= DISP_ERR_NONE;
        end else if (w_hs && !w_legal) begin
            r_err <= DISP_ERR_ILLEGAL_CTL;
        end else begin
            r_err <= DISP_ERR_NONE;
        end
    end

    assign bus.illegal_o = (r_err == DISP_ERR_ILLEGAL_CTL);

`ifdef DUMMY_ACC_DISPATCH_PERF_EN
    logic [31:0] r_issue_cnt [N_UNITS];
    logic [31:0] r_stall_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    for (genvar k = 0; k < N_UNITS; k++) begin : g_issue_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_issue_cnt[k] <= '0;
            end else if (w_push && (w_sel == UIDX_W'(k)) && (r_issue_cnt[k] != '1)) begin
                r_issue_cnt[k] <= r_issue_cnt[k] + 32'd1;
            end
        end
        assign issue_cnt_o[k] = r_issue_cnt[k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (bus.valid_i && !w_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    for (genvar k = 0; k < N_UNITS; k++) begin : g_issue_cnt
        assign issue_cnt_o[k] = '0;
    end
    assign stall_cnt_o = '0;
`endif

endmodule
